// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, sequences multi-cycle EX ops, applies flushes.
// Optional stall perf counter is built when STALL_PERF_CNT_EN is defined.
//
// state   | meaning
// IDLE    | no multi-cycle op; a start here is accepted and stalls this cycle
// MC_RUN  | op in flight, counter holds remaining stall cycles
// MC_DONE | result valid in EX; held while MEM stalls
module pipe_ctrl #(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_if,
  input  logic                stallreq_id,
  input  logic                stallreq_ex,
  input  logic                stallreq_mem,
  input  logic                ex_mc_start,
  input  logic [MC_CNT_W-1:0] ex_mc_cycles,
  input  logic                flush_req,
  input  logic [31:0]         flush_pc,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [31:0]         new_pc,
  output logic                mc_busy,
  output logic                mc_done,
  output logic [31:0]         stall_cycles
);
  localparam int STALL_W = 6;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

  typedef enum logic [1:0] {IDLE, MC_RUN, MC_DONE} state_e;

  state_e              state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic [MC_CNT_W-1:0] mc_len;
  logic                mc_accept;

  assign mc_len    = (ex_mc_cycles == '0) ? MC_CNT_W'(1) : ex_mc_cycles;
  assign mc_accept = (state_q == IDLE) && ex_mc_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_req) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ex_mc_start) begin
            if (mc_len == MC_CNT_W'(1)) begin
              state_d = MC_DONE;
              cnt_d   = '0;
            end else begin
              state_d = MC_RUN;
              cnt_d   = mc_len - MC_CNT_W'(1);
            end
          end
        end
        MC_RUN: begin
          cnt_d = cnt_q - MC_CNT_W'(1);
          // <=1 also catches an impossible zero count instead of wrapping
          if (cnt_q <= MC_CNT_W'(1)) begin
            state_d = MC_DONE;
            cnt_d   = '0;
          end
        end
        MC_DONE: begin
          if (!stallreq_mem) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, even with requests present.
  always_comb begin
    logic ex_src;
    ex_src  = stallreq_ex || (state_q == MC_RUN) || mc_accept;
    stall   = STALL_NONE;
    flush   = 1'b0;
    new_pc  = 32'h0;
    mc_busy = 1'b0;
    mc_done = 1'b0;
    if (rst) begin
      if (flush_req) begin
        flush  = 1'b1;
        new_pc = flush_pc;
      end else begin
        mc_busy = (state_q == MC_RUN) || mc_accept;
        mc_done = (state_q == MC_DONE);
        if (stallreq_mem)     stall = STALL_MEM;
        else if (ex_src)      stall = STALL_EX;
        else if (stallreq_id) stall = STALL_ID;
        else if (stallreq_if) stall = STALL_IF;
      end
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall[0] && !flush && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cycles_q <= 32'h0;
    else      stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: priority vectors, multi-cycle corner sequences,
// and randomized traffic against a cycle-indexed reference model.
module tb_pipe_ctrl;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy, mc_done;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  pipe_ctrl #(.MC_CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
    .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .mc_busy(mc_busy), .mc_done(mc_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drv(input logic s, input logic [5:0] n, input logic mem,
                     input logic fl, input logic [31:0] pc);
    @(negedge clk);
    stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0;
    stallreq_mem = mem; ex_mc_start = s; ex_mc_cycles = n;
    flush_req = fl; flush_pc = pc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    ex_mc_start = 1'b0; ex_mc_cycles = '0; flush_req = 1'b0; flush_pc = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, ".stall"}, 32'(stall), 32'h0);
    chk({nm, ".busy"}, 32'(mc_busy), 32'h0);
    chk({nm, ".done"}, 32'(mc_done), 32'h0);
  endtask

  typedef struct {
    logic       r_if, r_id, r_ex, r_mem, fl;
    logic [31:0] pc;
    logic [5:0] e_stall;
    logic       e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[10];

  // Reference model state: op tracked by absolute cycle numbers.
  int  cyc;
  bit  in_op;
  int  op_end;
  longint perf;

  initial begin
    rst = 1'b0;
    stallreq_if = 1'b1; stallreq_id = 1'b1; stallreq_ex = 1'b1; stallreq_mem = 1'b1;
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd3; flush_req = 1'b1; flush_pc = 32'h1234_5678;
    #3;
    chk("rst.stall", 32'(stall), 32'h0);
    chk("rst.flush", 32'(flush), 32'h0);
    chk("rst.new_pc", new_pc, 32'h0);
    chk("rst.busy", 32'(mc_busy), 32'h0);
    chk("rst.done", 32'(mc_done), 32'h0);
    chk("rst.perf", stall_cycles, 32'h0);
    do_reset();

    vecs[0] = '{0,0,0,0,0, 32'h0,        6'b000000, 0, 32'h0};
    vecs[1] = '{1,0,0,0,0, 32'h0,        6'b000011, 0, 32'h0};
    vecs[2] = '{0,1,0,0,0, 32'h0,        6'b000111, 0, 32'h0};
    vecs[3] = '{0,1,0,1,0, 32'h0,        6'b011111, 0, 32'h0};
    vecs[4] = '{0,0,1,0,0, 32'h0,        6'b001111, 0, 32'h0};
    vecs[5] = '{1,1,1,0,0, 32'h0,        6'b001111, 0, 32'h0};
    vecs[6] = '{1,1,1,1,0, 32'h0,        6'b011111, 0, 32'h0};
    vecs[7] = '{1,1,0,0,0, 32'hAAAA5555, 6'b000111, 0, 32'h0};
    vecs[8] = '{0,1,1,1,1, 32'hBFC00380, 6'b000000, 1, 32'hBFC00380};
    vecs[9] = '{1,0,0,0,1, 32'h8000_0000,6'b000000, 1, 32'h8000_0000};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stallreq_if = vecs[i].r_if; stallreq_id = vecs[i].r_id;
      stallreq_ex = vecs[i].r_ex; stallreq_mem = vecs[i].r_mem;
      ex_mc_start = 1'b0; ex_mc_cycles = '0;
      flush_req = vecs[i].fl; flush_pc = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d.flush", i), 32'(flush), 32'(vecs[i].e_flush));
      chk($sformatf("vec%0d.new_pc", i), new_pc, vecs[i].e_pc);
    end

    // N=4 op, then perf count, then reset mid-op
    do_reset();
    for (int t = 0; t < 4; t++) begin
      drv(t == 0, 6'd4, 0, 0, 0);
      chk($sformatf("n4.T%0d.stall", t), 32'(stall), 32'h0F);
      chk($sformatf("n4.T%0d.busy", t), 32'(mc_busy), 32'h1);
      chk($sformatf("n4.T%0d.done", t), 32'(mc_done), 32'h0);
    end
    drv(0, 0, 0, 0, 0);
    chk("n4.T4.done", 32'(mc_done), 32'h1);
    chk("n4.T4.stall", 32'(stall), 32'h0);
    chk("n4.T4.busy", 32'(mc_busy), 32'h0);
    drv(0, 0, 0, 0, 0);
    chk_quiet("n4.T5");
    chk("n4.perf", stall_cycles, PERF ? 32'd4 : 32'd0);
    drv(1, 6'd6, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk_quiet("midrst");
    chk("midrst.perf", stall_cycles, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 8; t++) begin
      drv(0, 0, 0, 0, 0);
      chk_quiet($sformatf("postrst%0d", t));
    end

    // N=1 and N=0 behave identically
    for (int k = 0; k < 2; k++) begin
      logic [5:0] nn;
      nn = (k == 0) ? 6'd1 : 6'd0;
      drv(1, nn, 0, 0, 0);
      chk($sformatf("n%0d.T0.stall", nn), 32'(stall), 32'h0F);
      chk($sformatf("n%0d.T0.busy", nn), 32'(mc_busy), 32'h1);
      drv(0, 0, 0, 0, 0);
      chk($sformatf("n%0d.T1.done", nn), 32'(mc_done), 32'h1);
      chk($sformatf("n%0d.T1.stall", nn), 32'(stall), 32'h0);
      drv(0, 0, 0, 0, 0);
      chk_quiet($sformatf("n%0d.T2", nn));
    end

    // N=5 aborted by a flush at T2
    drv(1, 6'd5, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 32'hBFC00380);
    chk("abort.flush", 32'(flush), 32'h1);
    chk("abort.new_pc", new_pc, 32'hBFC00380);
    chk_quiet("abort.T2");
    for (int t = 3; t < 9; t++) begin
      drv(0, 0, 0, 0, 0);
      chk_quiet($sformatf("abort.T%0d", t));
      chk($sformatf("abort.T%0d.pc", t), new_pc, 32'h0);
    end

    // flush together with a start in IDLE discards the start
    drv(1, 6'd3, 0, 1, 32'h0000_0180);
    chk("fstart.flush", 32'(flush), 32'h1);
    chk_quiet("fstart.T0");
    drv(0, 0, 0, 0, 0);
    chk_quiet("fstart.T1");

    // N=2 with MEM stall while the result is waiting
    drv(1, 6'd2, 0, 0, 0);
    chk("mem.T0.stall", 32'(stall), 32'h0F);
    drv(0, 0, 0, 0, 0);
    chk("mem.T1.stall", 32'(stall), 32'h0F);
    chk("mem.T1.busy", 32'(mc_busy), 32'h1);
    for (int t = 2; t < 4; t++) begin
      drv(1, 6'd3, 1, 0, 0);
      chk($sformatf("mem.T%0d.stall", t), 32'(stall), 32'h1F);
      chk($sformatf("mem.T%0d.done", t), 32'(mc_done), 32'h1);
      chk($sformatf("mem.T%0d.busy", t), 32'(mc_busy), 32'h0);
    end
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk_quiet("mem.T5");

    // Randomized traffic against the reference model
    do_reset();
    cyc = 0; in_op = 0; op_end = 0; perf = 0;
    for (int it = 0; it < 3000; it++) begin
      logic r_if, r_id, r_ex, r_mem, s, fl;
      logic [5:0] n;
      logic [31:0] pc;
      bit busy_e, done_e;
      logic [5:0] st_e;
      r_if = ($urandom_range(0, 3) == 0); r_id = ($urandom_range(0, 3) == 0);
      r_ex = ($urandom_range(0, 5) == 0); r_mem = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 2) == 0); n = 6'($urandom_range(0, 7));
      fl = ($urandom_range(0, 19) == 0); pc = $urandom;
      @(negedge clk);
      stallreq_if = r_if; stallreq_id = r_id; stallreq_ex = r_ex; stallreq_mem = r_mem;
      ex_mc_start = s; ex_mc_cycles = n; flush_req = fl; flush_pc = pc;
      #1;
      if (!in_op && s) begin
        in_op = 1;
        op_end = cyc + ((n == 0) ? 1 : int'(n));
      end
      busy_e = in_op && (cyc < op_end) && !fl;
      done_e = in_op && (cyc >= op_end) && !fl;
      if (fl)                  st_e = 6'b000000;
      else if (r_mem)          st_e = 6'b011111;
      else if (r_ex || busy_e) st_e = 6'b001111;
      else if (r_id)           st_e = 6'b000111;
      else if (r_if)           st_e = 6'b000011;
      else                     st_e = 6'b000000;
      chk("rnd.stall", 32'(stall), 32'(st_e));
      chk("rnd.flush", 32'(flush), 32'(fl));
      chk("rnd.new_pc", new_pc, fl ? pc : 32'h0);
      chk("rnd.busy", 32'(mc_busy), 32'(busy_e));
      chk("rnd.done", 32'(mc_done), 32'(done_e));
      chk("rnd.perf", stall_cycles, PERF ? 32'(perf) : 32'h0);
      if (st_e[0]) perf++;
      if (fl || (done_e && !r_mem)) in_op = 0;
      cyc++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
